// File: rtl/deflate_sched_pkg.sv
// Shared constants and arbiter state encoding for the 16-way round-robin scheduler.
package deflate_sched_pkg;

   localparam int unsigned NREQ  = 16;
   localparam int unsigned SEL_W = 5;

   typedef enum logic {
      StArb  = 1'b0,
      StLock = 1'b1
   } sched_state_e;

   function automatic logic [3:0] wrap_inc(input logic [3:0] idx);
      return idx + 4'd1;
   endfunction

endpackage

// File: rtl/rr_prio_enc16.sv
// Rotating find-first: returns the first set req bit at or after ptr, modulo 16.
module rr_prio_enc16 (
   input  logic [15:0] req,
   input  logic [3:0]  ptr,
   output logic [3:0]  gnt_idx,
   output logic        gnt_any
);

   logic [3:0] idx;

   // Walk offsets high to low so the smallest offset from ptr is the last writer.
   always_comb begin
      gnt_idx = ptr;
      gnt_any = 1'b0;
      idx     = '0;
      for (int i = 15; i >= 0; i--) begin
         idx = ptr + 4'(i);
         if (req[idx]) begin
            gnt_idx = idx;
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux16_rr_sched.sv
// 16-to-1 round-robin scheduler with a one-deep registered output stage.
// Define RR_LOCK_EN to hold the grant on one requester until its in_last beat.
module mux16_rr_sched
   import deflate_sched_pkg::*;
#(
   parameter int unsigned N    = 8,
   parameter int unsigned NREQ = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   in_valid,
   input  logic [NREQ*N-1:0] in_data,
   input  logic [NREQ-1:0]   in_last,
   output logic [NREQ-1:0]   in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N-1:0]      out_data,
   output logic [SEL_W-1:0]  out_sel,
   output logic              out_last
);

   if (NREQ != deflate_sched_pkg::NREQ) begin : g_bad_nreq
      $error("mux16_rr_sched supports only NREQ=16");
   end

   logic             out_valid_q;
   logic [N-1:0]     out_data_q;
   logic [3:0]       out_idx_q;
   logic [3:0]       ptr_q, ptr_d;
   logic             load, xfer;
   logic [3:0]       enc_idx, gnt;
   logic             enc_any, gnt_any;

   rr_prio_enc16 u_enc (
      .req     (in_valid),
      .ptr     (ptr_q),
      .gnt_idx (enc_idx),
      .gnt_any (enc_any)
   );

   assign load = ~out_valid_q | out_ready;
   assign xfer = gnt_any & load & ~rst;

`ifdef RR_LOCK_EN
   sched_state_e state_q, state_d;
   logic [3:0]   lock_id_q, lock_id_d;
   logic         out_last_q;

   always_comb begin
      gnt       = enc_idx;
      gnt_any   = enc_any;
      state_d   = state_q;
      lock_id_d = lock_id_q;
      ptr_d     = ptr_q;
      if (state_q == StLock) begin
         gnt     = lock_id_q;
         gnt_any = in_valid[lock_id_q];
      end
      if (xfer) begin
         unique case (state_q)
            StArb: begin
               ptr_d = wrap_inc(gnt);
               if (!in_last[gnt]) begin
                  state_d   = StLock;
                  lock_id_d = gnt;
               end
            end
            StLock: begin
               if (in_last[gnt]) begin
                  state_d = StArb;
                  ptr_d   = wrap_inc(lock_id_q);
               end
            end
            default: state_d = StArb;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StArb;
         lock_id_q  <= '0;
         out_last_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
         if (xfer) out_last_q <= in_last[gnt];
      end
   end

   assign out_last = out_last_q;
`else
   logic unused_in_last;

   assign unused_in_last = ^in_last;
   assign gnt            = enc_idx;
   assign gnt_any        = enc_any;
   assign ptr_d          = xfer ? wrap_inc(gnt) : ptr_q;
   assign out_last       = 1'b1;
`endif

   always_comb begin
      in_ready = '0;
      if (xfer) in_ready[gnt] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         ptr_q       <= '0;
      end else begin
         // gnt_any under load implies a transfer; payload holds when idle.
         if (load) out_valid_q <= gnt_any;
         if (xfer) begin
            out_data_q <= in_data[int'(gnt)*N +: N];
            out_idx_q  <= gnt;
         end
         ptr_q <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = {1'b0, out_idx_q};

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Scoreboard bench for mux16_rr_sched; expected beats are queued by the stimulus.
module tb_mux16_rr_sched;

   localparam int N = 8;
`ifdef RR_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [15:0]     in_valid = '0;
   logic [16*N-1:0] in_data;
   logic [15:0]     in_last = '0;
   logic [15:0]     in_ready;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [N-1:0]    out_data;
   logic [4:0]      out_sel;
   logic            out_last;

   typedef struct packed {
      logic [4:0]   sel;
      logic [N-1:0] data;
      logic         last;
   } beat_t;

   beat_t exp_q[$];
   int    total = 0;
   int    bad   = 0;
   int    beats = 0;

   mux16_rr_sched #(.N(N), .NREQ(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] dat(input int i);
      return 8'(8'hA0 + i * 7);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push(input int s, input logic l);
      beat_t b;
      b.sel  = 5'(s);
      b.data = dat(s);
      b.last = LOCK ? l : 1'b1;
      exp_q.push_back(b);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted output beat is matched against the queue head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         beat_t e;
         beats++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got sel %0d with no expected beat", out_sel);
         end else begin
            e = exp_q.pop_front();
            check("beat_sel", 32'(out_sel), 32'(e.sel));
            check("beat_data", 32'(out_data), 32'(e.data));
            check("beat_last", 32'(out_last), 32'(e.last));
         end
      end
   end

   initial begin
      int b0;
      for (int i = 0; i < 16; i++) in_data[i*N +: N] = dat(i);

      // Reset with every requester valid: nothing may be accepted.
      in_valid = 16'hFFFF;
      in_last  = 16'hFFFF;
      tick();
      check("rst_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_sel", 32'(out_sel), 32'h0);
      check("rst_data", 32'(out_data), 32'h0);
      check("rst_last", 32'(out_last), LOCK ? 32'h0 : 32'h1);

      // All valid, ready high: 0..15 then 0, one beat per cycle.
      rst = 1'b0;
      for (int k = 0; k < 17; k++) push(k % 16, 1'b1);
      b0 = beats;
      repeat (17) tick();
      in_valid = '0;
      tick();
      check("full_rate_beats", 32'(beats - b0), 32'd17);
      check("full_rate_idle", 32'(out_valid), 32'h0);

      // Bring ptr to 15, then 15/0 wrap, then ptr=1 proves the wrap.
      in_valid = 16'h4000;
      push(14, 1'b1);
      tick();
      in_valid = 16'h8001;
      push(15, 1'b1);
      push(0, 1'b1);
      tick();
      tick();
      in_valid = 16'h0003;
      push(1, 1'b1);
      tick();
      in_valid = '0;
      tick();
      check("wrap_drained", 32'(exp_q.size()), 32'h0);

      // Output stall for 5 cycles.
      in_valid = 16'hFFFF;
      push(2, 1'b1);
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("stall_valid", 32'(out_valid), 32'h1);
         check("stall_sel", 32'(out_sel), 32'd2);
         check("stall_data", 32'(out_data), 32'(dat(2)));
         check("stall_in_ready", 32'(in_ready), 32'h0);
      end
      out_ready = 1'b1;
      #1;
      check("release_in_ready", 32'(in_ready), 32'h0008);
      push(3, 1'b1);
      tick();
      in_valid = '0;
      tick();
      check("stall_drained", 32'(exp_q.size()), 32'h0);

      // Sole requester 7 for 4 cycles.
      in_valid = 16'h0080;
      repeat (4) push(7, 1'b1);
      b0 = beats;
      repeat (4) tick();
      in_valid = '0;
      tick();
      check("sole_beats", 32'(beats - b0), 32'd4);

      // Requester 3 sends a 3-beat packet while requester 4 is valid.
      in_valid = 16'h0018;
      in_last  = 16'h0010;
      if (LOCK) begin
         push(3, 1'b0);
         push(3, 1'b0);
         push(3, 1'b1);
         push(4, 1'b1);
      end else begin
         push(3, 1'b1);
         push(4, 1'b1);
         push(3, 1'b1);
         push(4, 1'b1);
      end
      tick();
      tick();
      in_last = 16'h0018;
      tick();
      tick();
      in_valid = '0;
      tick();
      check("packet_drained", 32'(exp_q.size()), 32'h0);

      // Reset while a beat is held (and, with locking, a lock is taken).
      in_last   = '0;
      in_valid  = 16'hFFFF;
      out_ready = 1'b0;
      tick();
      check("pre_rst_held", 32'(out_valid), 32'h1);
      tick();
      rst       = 1'b1;
      out_ready = 1'b1;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("mid_rst_valid", 32'(out_valid), 32'h0);
      rst      = 1'b0;
      in_valid = 16'h0026;
      in_last  = 16'hFFFF;
      push(1, 1'b1);
      push(2, 1'b1);
      push(5, 1'b1);
      repeat (3) tick();
      in_valid = '0;
      tick();
      tick();
      check("final_empty", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
